// File: rtl/hash_wb_queue_top.sv
// hash_wb_queue_top: Wishbone B3 slave front-end for a block-hash core.
// Message blocks are assembled in a staging register file, committed into a
// block FIFO, fed to the core by a small FSM, and the resulting digests are
// queued in a result FIFO that software drains through the register map.
// Optional feature macro: HASH_WB_IRQ_EN (adds irq_o and the IRQ_EN register).
module hash_wb_queue_top #(
    parameter int BLOCK_W      = 512,
    parameter int DIGEST_W     = 128,
    parameter int QUEUE_DEPTH  = 4,
    parameter int RESULT_DEPTH = 4
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_ni,
    input  logic [31:0]         wb_adr_i,
    input  logic [31:0]         wb_dat_i,
    input  logic [3:0]          wb_sel_i,
    input  logic                wb_we_i,
    input  logic                wb_stb_i,
    input  logic                wb_cyc_i,
    output logic [31:0]         wb_dat_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic                wb_rty_o,
`ifdef HASH_WB_IRQ_EN
    output logic                irq_o,
`endif
    output logic                core_rst_o,
    output logic [BLOCK_W-1:0]  core_msg_o,
    output logic                core_start_o,
    input  logic                core_ready_i,
    input  logic [DIGEST_W-1:0] core_digest_i,
    input  logic                core_valid_i
);

    localparam int MSG_WORDS = BLOCK_W / 32;
    localparam int DIG_WORDS = DIGEST_W / 32;
    localparam int QAW       = $clog2(QUEUE_DEPTH);
    localparam int RAW       = $clog2(RESULT_DEPTH);
    localparam logic [QAW:0] Q_FULL_CNT = (QAW+1)'(QUEUE_DEPTH);
    localparam logic [RAW:0] R_FULL_CNT = (RAW+1)'(RESULT_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_STORE} state_t;

    state_t                state_q, state_d;
    logic                  ack_q, ack_d, err_q, err_d;
    logic [31:0]           dat_q, dat_d;
    logic                  core_rst_q, core_rst_d;
    logic                  core_start_q, core_start_d;
    logic [BLOCK_W-1:0]    core_msg_q, core_msg_d;
    logic [DIGEST_W-1:0]   dig_hold_q, dig_hold_d;
    logic [31:0]           stg_q [MSG_WORDS];
    logic [31:0]           stg_d [MSG_WORDS];
    logic [BLOCK_W-1:0]    q_mem_q [QUEUE_DEPTH];
    logic [BLOCK_W-1:0]    q_mem_d [QUEUE_DEPTH];
    logic [DIGEST_W-1:0]   r_mem_q [RESULT_DEPTH];
    logic [DIGEST_W-1:0]   r_mem_d [RESULT_DEPTH];
    logic [QAW-1:0]        q_wr_q, q_wr_d, q_rd_q, q_rd_d;
    logic [QAW:0]          q_count_q, q_count_d;
    logic [RAW-1:0]        r_wr_q, r_wr_d, r_rd_q, r_rd_d;
    logic [RAW:0]          r_count_q, r_count_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
`ifdef HASH_WB_IRQ_EN
    logic [1:0]            irq_en_q, irq_en_d;
    logic                  irq_q, irq_d;
`endif

    logic [6:0]            widx;
    logic                  unused_adr;
    assign widx       = wb_adr_i[8:2];
    assign unused_adr = ^{wb_adr_i[31:9], wb_adr_i[1:0]};

    // Bus decode, register writes, FIFO bookkeeping and FSM next state
    always_comb begin
        logic                 acc, adr_ok, adr_ro, ok, wr;
        logic                 ctrl_wr, flush, commit, pop;
        logic                 q_full, r_full, r_empty, busy;
        logic                 q_push_ok, r_pop_ok, fsm_pop, r_push;
        logic [31:0]          rd_word, status;
        logic [BLOCK_W-1:0]   blk;

        state_d      = state_q;
        ack_d        = 1'b0;
        err_d        = 1'b0;
        dat_d        = '0;
        core_rst_d   = 1'b0;
        core_msg_d   = core_msg_q;
        dig_hold_d   = dig_hold_q;
        stg_d        = stg_q;
        q_mem_d      = q_mem_q;
        r_mem_d      = r_mem_q;
        q_wr_d       = q_wr_q;
        q_rd_d       = q_rd_q;
        r_wr_d       = r_wr_q;
        r_rd_d       = r_rd_q;
        ovf_d        = ovf_q;
        unf_d        = unf_q;
        fsm_pop      = 1'b0;
        r_push       = 1'b0;
        adr_ok       = 1'b0;
        adr_ro       = 1'b0;
        rd_word      = '0;
        blk          = '0;
`ifdef HASH_WB_IRQ_EN
        irq_en_d     = irq_en_q;
`endif

        q_full  = (q_count_q == Q_FULL_CNT);
        r_full  = (r_count_q == R_FULL_CNT);
        r_empty = (r_count_q == '0);
        busy    = (state_q != S_IDLE);
        status  = {8'h00, 8'(r_count_q), 8'(q_count_q), 3'b000,
                   unf_q, ovf_q, r_empty, q_full, busy};

        // Address decode and read mux
        if (widx == 7'd0) begin
            adr_ok = 1'b1;
        end
        if (widx == 7'd1) begin
            adr_ok  = 1'b1;
            adr_ro  = 1'b1;
            rd_word = status;
        end
        if (widx == 7'd2) begin
            adr_ok = 1'b1;
`ifdef HASH_WB_IRQ_EN
            rd_word = {30'h0, irq_en_q};
`endif
        end
        for (int i = 0; i < MSG_WORDS; i++) begin
            if (widx == 7'(64 + i)) begin
                adr_ok  = 1'b1;
                rd_word = stg_q[i];
            end
        end
        for (int j = 0; j < DIG_WORDS; j++) begin
            if (widx == 7'(96 + j)) begin
                adr_ok = 1'b1;
                adr_ro = 1'b1;
                if (!r_empty) begin
                    rd_word = r_mem_q[r_rd_q][DIGEST_W-1-32*j -: 32];
                end
            end
        end

        acc   = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;
        ok    = acc & adr_ok & ~(wb_we_i & adr_ro);
        ack_d = ok;
        err_d = acc & ~ok;
        wr    = ok & wb_we_i;
        if (ok && !wb_we_i) begin
            dat_d = rd_word;
        end

        ctrl_wr = wr & (widx == 7'd0) & wb_sel_i[0];
        flush   = ctrl_wr & wb_dat_i[1];
        commit  = ctrl_wr & wb_dat_i[0] & ~wb_dat_i[1];
        pop     = ctrl_wr & wb_dat_i[2] & ~wb_dat_i[1];

`ifdef HASH_WB_IRQ_EN
        if (wr && widx == 7'd2 && wb_sel_i[0]) begin
            irq_en_d = wb_dat_i[1:0];
        end
`endif

        for (int i = 0; i < MSG_WORDS; i++) begin
            if (wr && widx == 7'(64 + i)) begin
                for (int b = 0; b < 4; b++) begin
                    if (wb_sel_i[b]) begin
                        stg_d[i][8*b +: 8] = wb_dat_i[8*b +: 8];
                    end
                end
            end
            blk[BLOCK_W-1-32*i -: 32] = stg_q[i];
        end

        // Core sequencing
        case (state_q)
            S_IDLE: begin
                if (q_count_q != '0 && core_ready_i) begin
                    state_d    = S_LOAD;
                    core_msg_d = q_mem_q[q_rd_q];
                    fsm_pop    = 1'b1;
                end
            end
            S_LOAD:  state_d = S_WAIT;
            S_WAIT: begin
                if (core_valid_i) begin
                    state_d    = S_STORE;
                    dig_hold_d = core_digest_i;
                end
            end
            S_STORE: begin
                if (!r_full) begin
                    r_push  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Block queue: fullness is judged before the FSM pop of this cycle
        q_push_ok = commit & ~q_full;
        if (commit && q_full) begin
            ovf_d = 1'b1;
        end
        if (q_push_ok) begin
            q_mem_d[q_wr_q] = blk;
            q_wr_d          = q_wr_q + QAW'(1);
        end
        if (fsm_pop) begin
            q_rd_d = q_rd_q + QAW'(1);
        end
        q_count_d = q_count_q + (QAW+1)'(q_push_ok) - (QAW+1)'(fsm_pop);

        // Result queue: a pop on empty flags underflow even when a push lands
        r_pop_ok = pop & ~r_empty;
        if (pop && r_empty) begin
            unf_d = 1'b1;
        end
        if (r_push) begin
            r_mem_d[r_wr_q] = dig_hold_q;
            r_wr_d          = r_wr_q + RAW'(1);
        end
        if (r_pop_ok) begin
            r_rd_d = r_rd_q + RAW'(1);
        end
        r_count_d = r_count_q + (RAW+1)'(r_push) - (RAW+1)'(r_pop_ok);

        // FLUSH overrides everything else in the same write
        if (flush) begin
            q_wr_d     = '0;
            q_rd_d     = '0;
            q_count_d  = '0;
            r_wr_d     = '0;
            r_rd_d     = '0;
            r_count_d  = '0;
            ovf_d      = 1'b0;
            unf_d      = 1'b0;
            state_d    = S_IDLE;
            core_rst_d = 1'b1;
        end
        core_start_d = (state_q == S_LOAD) & ~flush;

`ifdef HASH_WB_IRQ_EN
        irq_d = (irq_en_d[0] & (r_count_d != '0)) | (irq_en_d[1] & (ovf_d | unf_d));
`endif
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q      <= S_IDLE;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            dat_q        <= '0;
            core_rst_q   <= 1'b0;
            core_start_q <= 1'b0;
            core_msg_q   <= '0;
            dig_hold_q   <= '0;
            stg_q        <= '{default: '0};
            q_mem_q      <= '{default: '0};
            r_mem_q      <= '{default: '0};
            q_wr_q       <= '0;
            q_rd_q       <= '0;
            q_count_q    <= '0;
            r_wr_q       <= '0;
            r_rd_q       <= '0;
            r_count_q    <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
`ifdef HASH_WB_IRQ_EN
            irq_en_q     <= '0;
            irq_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            dat_q        <= dat_d;
            core_rst_q   <= core_rst_d;
            core_start_q <= core_start_d;
            core_msg_q   <= core_msg_d;
            dig_hold_q   <= dig_hold_d;
            stg_q        <= stg_d;
            q_mem_q      <= q_mem_d;
            r_mem_q      <= r_mem_d;
            q_wr_q       <= q_wr_d;
            q_rd_q       <= q_rd_d;
            q_count_q    <= q_count_d;
            r_wr_q       <= r_wr_d;
            r_rd_q       <= r_rd_d;
            r_count_q    <= r_count_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
`ifdef HASH_WB_IRQ_EN
            irq_en_q     <= irq_en_d;
            irq_q        <= irq_d;
`endif
        end
    end

    assign wb_dat_o     = dat_q;
    assign wb_ack_o     = ack_q;
    assign wb_err_o     = err_q;
    assign wb_rty_o     = 1'b0;
    assign core_rst_o   = core_rst_q;
    assign core_msg_o   = core_msg_q;
    assign core_start_o = core_start_q;
`ifdef HASH_WB_IRQ_EN
    assign irq_o        = irq_q;
`endif

endmodule

// File: tb/tb_hash_wb_queue_top.sv
// Directed bench for hash_wb_queue_top with a behavioural hash-core stub.
module tb_hash_wb_queue_top;

    localparam logic [127:0] MD5_ABC = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 32'h18000000, 32'h0};

    logic         wb_clk_i, wb_rst_ni;
    logic [31:0]  wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]   wb_sel_i;
    logic         wb_we_i, wb_stb_i, wb_cyc_i;
    logic         wb_ack_o, wb_err_o, wb_rty_o;
    logic         core_rst_o, core_start_o, core_ready_i, core_valid_i;
    logic [511:0] core_msg_o;
    logic [127:0] core_digest_i;
`ifdef HASH_WB_IRQ_EN
    logic         irq_o;
`endif

    int           checks = 0;
    int           failures = 0;
    logic         last_ack, last_err, rst_seen;
    logic         stub_auto;
    logic [31:0]  rd;
    logic [31:0]  abc_w [16];
    logic [31:0]  exp_head [4];

    hash_wb_queue_top dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .wb_adr_i(wb_adr_i),
        .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i),
        .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
`ifdef HASH_WB_IRQ_EN
        .irq_o(irq_o),
`endif
        .core_rst_o(core_rst_o), .core_msg_o(core_msg_o),
        .core_start_o(core_start_o), .core_ready_i(core_ready_i),
        .core_digest_i(core_digest_i), .core_valid_i(core_valid_i)
    );

    initial begin
        wb_clk_i = 1'b0;
        forever #5 wb_clk_i = ~wb_clk_i;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wb_acc(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rdat);
        @(negedge wb_clk_i);
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(posedge wb_clk_i); #1;
        last_ack = wb_ack_o; last_err = wb_err_o; rst_seen = core_rst_o; rdat = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(posedge wb_clk_i); #1;
    endtask

    task automatic wb_wr(input logic [31:0] adr, input logic [31:0] dat);
        logic [31:0] dummy;
        wb_acc(1'b1, adr, dat, 4'hF, dummy);
    endtask

    task automatic wb_rd(input logic [31:0] adr, output logic [31:0] dat);
        wb_acc(1'b0, adr, 32'h0, 4'hF, dat);
    endtask

    task automatic poll_status(input string tag, input logic [31:0] mask, input logic [31:0] val);
        logic [31:0] st;
        int n;
        n = 0;
        wb_rd(32'h4, st);
        while (((st & mask) != val) && n < 200) begin
            wb_rd(32'h4, st);
            n++;
        end
        check(tag, 512'(st & mask), 512'(val));
    endtask

    // Behavioural core: answers each start pulse three cycles later
    initial begin
        forever begin
            @(negedge wb_clk_i);
            if (stub_auto) begin
                core_valid_i = 1'b0;
                if (core_start_o) begin
                    repeat (3) @(negedge wb_clk_i);
                    core_digest_i = (core_msg_o == ABC_BLK) ? MD5_ABC : core_msg_o[511:384];
                    core_valid_i  = 1'b1;
                end
            end
        end
    end

    initial begin
        wb_rst_ni = 1'b0; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
        wb_we_i = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        core_ready_i = 1'b1; core_valid_i = 1'b0; core_digest_i = '0; stub_auto = 1'b1;
        for (int i = 0; i < 16; i++) abc_w[i] = 32'h0;
        abc_w[0] = 32'h61626380; abc_w[14] = 32'h18000000;

        #1;
        check("rst_ack", 512'(wb_ack_o), 512'(0));
        check("rst_err", 512'(wb_err_o), 512'(0));
        check("rst_start", 512'(core_start_o), 512'(0));
        check("rst_msg", core_msg_o, 512'(0));
        check("rst_core_rst", 512'(core_rst_o), 512'(0));
        repeat (3) @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        wb_rd(32'h4, rd);
        check("rst_status", 512'(rd), 512'(32'h4));

        // MD5 "abc": staging, byte lanes, commit latency, digest order
        for (int i = 0; i < 16; i++) wb_wr(32'h100 + 32'(4*i), abc_w[i]);
        begin
            logic [31:0] dummy;
            wb_acc(1'b1, 32'h104, 32'hFFFF_FFFF, 4'b0101, dummy);
        end
        wb_rd(32'h104, rd);
        check("stg_lanes", 512'(rd), 512'(32'h00FF00FF));
        wb_wr(32'h104, 32'h0);
        wb_rd(32'h100, rd);
        check("stg_w0", 512'(rd), 512'(32'h61626380));
        wb_wr(32'h0, 32'h1);
        check("commit_ack", 512'(last_ack), 512'(1));
        check("start_lat1", 512'(core_start_o), 512'(0));
        @(posedge wb_clk_i); #1;
        check("start_lat2", 512'(core_start_o), 512'(1));
        check("msg_abc", core_msg_o, ABC_BLK);
        @(posedge wb_clk_i); #1;
        check("start_pulse", 512'(core_start_o), 512'(0));
        poll_status("abc_done", 32'h4, 32'h0);
        wb_rd(32'h4, rd);
        check("abc_status", 512'(rd), 512'(32'h00010000));
        for (int j = 0; j < 4; j++) begin
            wb_rd(32'h180 + 32'(4*j), rd);
            check("md5_word", 512'(rd), 512'(MD5_ABC[127-32*j -: 32]));
        end
        wb_wr(32'h0, 32'h4);
        wb_rd(32'h4, rd);
        check("abc_popped", 512'(rd), 512'(32'h4));

        // Queue overflow with core held off
        core_ready_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            wb_wr(32'h100, 32'hB000_0000 + 32'(k));
            wb_wr(32'h0, 32'h1);
        end
        wb_rd(32'h4, rd);
        check("ovf_status", 512'(rd), 512'(32'h0000040E));
        core_ready_i = 1'b1;
        poll_status("drain4", 32'h00FFFF01, 32'h00040000);
        wb_rd(32'h4, rd);
        check("drain4_status", 512'(rd), 512'(32'h00040008));
        check("last_msg_b4", 512'(core_msg_o[511:480]), 512'(32'hB0000004));

        // Result FIFO full: fifth block stalls in STORE until a POP
        wb_wr(32'h100, 32'hC000_0005);
        wb_wr(32'h0, 32'h1);
        repeat (12) @(posedge wb_clk_i);
        #1;
        wb_rd(32'h4, rd);
        check("stall_status", 512'(rd), 512'(32'h00040009));
        check("stall_msg", 512'(core_msg_o[511:480]), 512'(32'hC0000005));
        wb_rd(32'h180, rd);
        check("head_b1", 512'(rd), 512'(32'hB0000001));
        wb_wr(32'h0, 32'h4);
        poll_status("unstall", 32'h00FFFF01, 32'h00040000);
        exp_head[0] = 32'hB0000002; exp_head[1] = 32'hB0000003;
        exp_head[2] = 32'hB0000004; exp_head[3] = 32'hC0000005;
        for (int k = 0; k < 4; k++) begin
            wb_rd(32'h180, rd);
            check("head_seq", 512'(rd), 512'(exp_head[k]));
            wb_rd(32'h18C, rd);
            check("head_w3", 512'(rd), 512'(0));
            wb_wr(32'h0, 32'h4);
        end
        wb_rd(32'h4, rd);
        check("empty_status", 512'(rd), 512'(32'h0000000C));
        wb_wr(32'h0, 32'h4);
        wb_rd(32'h4, rd);
        check("unf_status", 512'(rd), 512'(32'h0000001C));

        // Error responses
        wb_rd(32'h0FC, rd);
        check("err_rd_ack", 512'(last_ack), 512'(0));
        check("err_rd_err", 512'(last_err), 512'(1));
        check("err_one_cycle", 512'(wb_err_o), 512'(0));
        wb_wr(32'h4, 32'hFFFF_FFFF);
        check("err_wr_status", 512'(last_err), 512'(1));
        wb_wr(32'h180, 32'h1);
        check("err_wr_digest", 512'(last_err), 512'(1));
        wb_rd(32'h140, rd);
        check("err_stg_range", 512'(last_err), 512'(1));
        wb_rd(32'h8, rd);
        check("irqen_ack", 512'(last_ack), 512'(1));
        check("irqen_rd", 512'(rd), 512'(0));
        wb_rd(32'h4, rd);
        check("status_kept", 512'(rd), 512'(32'h0000001C));

        // FLUSH while the core is working; late digest must be ignored
        stub_auto = 1'b0;
        wb_wr(32'h0, 32'h1);
        repeat (4) @(posedge wb_clk_i);
        #1;
        wb_rd(32'h4, rd);
        check("wait_status", 512'(rd), 512'(32'h0000001D));
        wb_wr(32'h0, 32'h2);
        check("flush_rst", 512'(rst_seen), 512'(1));
        check("flush_rst_pulse", 512'(core_rst_o), 512'(0));
        @(negedge wb_clk_i);
        core_digest_i = 128'hDEAD; core_valid_i = 1'b1;
        @(negedge wb_clk_i);
        core_valid_i = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        wb_rd(32'h4, rd);
        check("flush_status", 512'(rd), 512'(32'h4));
        wb_rd(32'h180, rd);
        check("flush_digest", 512'(rd), 512'(0));

`ifdef HASH_WB_IRQ_EN
        stub_auto = 1'b1;
        wb_wr(32'h8, 32'h1);
        wb_rd(32'h8, rd);
        check("irqen_rb", 512'(rd), 512'(1));
        wb_wr(32'h0, 32'h1);
        poll_status("irq_done", 32'h4, 32'h0);
        check("irq_set", 512'(irq_o), 512'(1));
        wb_wr(32'h0, 32'h4);
        check("irq_clr", 512'(irq_o), 512'(0));
        stub_auto = 1'b0;
`endif

        // Asynchronous reset while waiting on the core
        wb_wr(32'h0, 32'h1);
        repeat (4) @(posedge wb_clk_i);
        #3;
        check("pre_arst_msg", 512'(core_msg_o[511:480]), 512'(32'hC0000005));
        wb_rst_ni = 1'b0;
        #1;
        check("arst_msg", core_msg_o, 512'(0));
        check("arst_start", 512'(core_start_o), 512'(0));
        check("arst_ack", 512'(wb_ack_o), 512'(0));
`ifdef HASH_WB_IRQ_EN
        check("arst_irq", 512'(irq_o), 512'(0));
`endif
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        wb_rd(32'h4, rd);
        check("arst_status", 512'(rd), 512'(32'h4));
        wb_rd(32'h100, rd);
        check("arst_stg", 512'(rd), 512'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
